// File: rtl/riscv_pkg.sv
// Shared RV32I core types: instruction classes, ALU/branch functions,
// sequencer states and trap causes.
package riscv_pkg;

  typedef enum logic [3:0] {
    OP, OPIMM, BRANCH, LUI, JAL, JALR, LOAD, STORE, AUIPC, Unsupported
  } Itype;

  typedef enum logic [3:0] {
    Add, Sub, And, Or, Xor, Slt, Sltu, Sll, Srl, Sra
  } AluFunc;

  typedef enum logic [2:0] {
    Eq, Neq, Lt, Ltu, Ge, Geu
  } BrFunc;

  typedef enum logic [3:0] {
    IDLE, FETCH, FETCH_WAIT, DECODE, EXECUTE, MEM, MEM_WAIT, WRITEBACK, TRAP
  } SeqState;

  localparam logic [1:0] CAUSE_NONE        = 2'd0;
  localparam logic [1:0] CAUSE_UNSUPPORTED = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGNED  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT     = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic writes_rd(Itype t);
    return t inside {OP, OPIMM, LUI, AUIPC, JAL, JALR, LOAD};
  endfunction

endpackage

// File: rtl/seq_mem_if.sv
// Shared memory port: drives the request for the current sequencer state,
// reports handshake completion and enforces the response timeout.
module seq_mem_if
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  SeqState     state,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        is_store,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        done,
  output logic        timeout
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] wait_cnt;
  logic          waiting;

  // Request fields derive only from state and latched values, so they stay
  // stable for as long as the FSM waits for ready.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_store;
        mem_addr  = addr;
        mem_wdata = is_store ? wdata : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    waiting = state inside {FETCH, FETCH_WAIT, MEM, MEM_WAIT};
    done    = ((state == FETCH || state == MEM) && mem_ready) ||
              ((state == FETCH_WAIT || state == MEM_WAIT) && mem_rvalid);
    timeout = waiting && !done && (wait_cnt == LAST);
  end

  // Every waiting state is entered from a non-waiting state or on completion
  // of the previous wait, so clearing here covers "clear on entry".
  always_ff @(posedge clk) begin
    if (!rst_n || !waiting || done) wait_cnt <= '0;
    else                            wait_cnt <= wait_cnt + CW'(1);
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: owns PC/instruction registers, sequences
// fetch/decode/execute/memory/writeback and arbitrates the shared memory port.
module core_sequencer
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        run_in,
  input  Itype        iType_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] rval2_in,
  input  logic [31:0] exec_data_in,
  input  logic [31:0] exec_addr_in,
  input  logic [31:0] exec_next_pc_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  input  logic        mem_ready_in,
  input  logic        mem_rvalid_in,
  input  logic [31:0] mem_rdata_in,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        we_out,
  output logic [4:0]  wa_out,
  output logic [31:0] wd_out,
  output logic [31:0] retired_out,
  output logic        trap_out,
  output logic [1:0]  trap_cause_out
);

  SeqState     state, state_next;
  logic [1:0]  cause_next;
  Itype        itype_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q, addr_q, npc_q, wdata_q, load_q;
  logic        done, timeout;

  seq_mem_if #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_if (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .state      (state),
    .pc         (pc_out),
    .addr       (addr_q),
    .wdata      (wdata_q),
    .is_store   (itype_q == STORE),
    .mem_ready  (mem_ready_in),
    .mem_rvalid (mem_rvalid_in),
    .mem_req    (mem_req_out),
    .mem_we     (mem_we_out),
    .mem_addr   (mem_addr_out),
    .mem_wdata  (mem_wdata_out),
    .done       (done),
    .timeout    (timeout)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    cause_next = CAUSE_NONE;
    unique case (state)
      IDLE:       if (run_in) state_next = FETCH;
      FETCH, FETCH_WAIT, MEM, MEM_WAIT: begin
        if (done) begin
          unique case (state)
            FETCH:      state_next = FETCH_WAIT;
            FETCH_WAIT: state_next = DECODE;
            MEM:        state_next = (itype_q == STORE) ? WRITEBACK : MEM_WAIT;
            default:    state_next = WRITEBACK;
          endcase
        end else if (timeout) begin
          state_next = TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      DECODE:     state_next = EXECUTE;
      EXECUTE: begin
        case (iType_in)
          LOAD, STORE: begin
            if (exec_addr_in[1:0] != 2'b00) begin
              state_next = TRAP;
              cause_next = CAUSE_MISALIGNED;
            end else begin
              state_next = MEM;
            end
          end
          OP, OPIMM, BRANCH, LUI, JAL, JALR, AUIPC: state_next = WRITEBACK;
          default: begin
            state_next = TRAP;
            cause_next = CAUSE_UNSUPPORTED;
          end
        endcase
      end
      WRITEBACK:  state_next = run_in ? FETCH : IDLE;
      TRAP:       state_next = TRAP;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    we_out = 1'b0;
    wa_out = '0;
    wd_out = '0;
    if (state == WRITEBACK) begin
      we_out = writes_rd(itype_q) && (rd_q != 5'd0);
      wa_out = rd_q;
      wd_out = (itype_q == LOAD) ? load_q : data_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      pc_out         <= RESET_PC;
      inst_out       <= NOP;
      itype_q        <= OP;
      rd_q           <= '0;
      data_q         <= '0;
      addr_q         <= '0;
      npc_q          <= '0;
      wdata_q        <= '0;
      load_q         <= '0;
      retired_out    <= '0;
      trap_out       <= 1'b0;
      trap_cause_out <= CAUSE_NONE;
    end else begin
      if (state == FETCH_WAIT && done) inst_out <= mem_rdata_in;
      if (state == EXECUTE) begin
        itype_q <= iType_in;
        rd_q    <= rd_in;
        data_q  <= exec_data_in;
        addr_q  <= exec_addr_in;
        npc_q   <= exec_next_pc_in;
        wdata_q <= rval2_in;
      end
      if (state == MEM_WAIT && done) load_q <= mem_rdata_in;
      if (state == WRITEBACK) begin
        pc_out      <= npc_q;
        retired_out <= retired_out + 32'd1;
      end
      if (state_next == TRAP && state != TRAP) begin
        trap_out       <= 1'b1;
        trap_cause_out <= cause_next;
      end
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer with a per-cycle memory responder and a
// writeback scoreboard.
module tb_core_sequencer;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_in, run_in;
  Itype        iType_in;
  logic [4:0]  rd_in;
  logic [31:0] rval2_in, exec_data_in, exec_addr_in, exec_next_pc_in;
  logic        mem_req_out, mem_we_out;
  logic [31:0] mem_addr_out, mem_wdata_out;
  logic        mem_ready_in, mem_rvalid_in;
  logic [31:0] mem_rdata_in;
  logic [31:0] pc_out, inst_out, wd_out, retired_out;
  logic        we_out, trap_out;
  logic [4:0]  wa_out;
  logic [1:0]  trap_cause_out;

  core_sequencer #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(8)) dut (
    .clk_in(clk), .rst_n_in(rst_n_in), .run_in(run_in), .iType_in(iType_in),
    .rd_in(rd_in), .rval2_in(rval2_in), .exec_data_in(exec_data_in),
    .exec_addr_in(exec_addr_in), .exec_next_pc_in(exec_next_pc_in),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_ready_in(mem_ready_in),
    .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in), .pc_out(pc_out),
    .inst_out(inst_out), .we_out(we_out), .wa_out(wa_out), .wd_out(wd_out),
    .retired_out(retired_out), .trap_out(trap_out), .trap_cause_out(trap_cause_out)
  );

  typedef struct packed { logic [4:0] wa; logic [31:0] wd; } wb_t;
  wb_t wb_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, we_count = 0, req_starts = 0, st_count = 0;
  bit in_req = 1'b0, rv_enable = 1'b1;
  int stall_left = 0, rv_cnt = 0, data_stall = 0, data_rv_lat = 1;
  logic [31:0] req_start_addr = '0, rv_data = '0, imem_word = '0;
  logic [31:0] ld_addr = '0, ld_data = '0, st_addr = '0, st_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    wb_t e;
    if (in_req) begin
      check("req_hold_req", 32'(mem_req_out), 32'd1);
      check("req_hold_addr", mem_addr_out, req_start_addr);
    end
    if (mem_req_out === 1'b1 && !in_req) begin
      req_starts++;
      req_start_addr = mem_addr_out;
    end
    if (we_out === 1'b1) begin
      we_count++;
      n_cmp++;
      assert (wb_q.size() != 0) else begin
        n_bad++;
        $error("FAIL we_unexpected: observed write wa=%0d wd=%h expected no write", wa_out, wd_out);
      end
      if (wb_q.size() != 0) begin
        e = wb_q.pop_front();
        check("wb_wa", 32'(wa_out), 32'(e.wa));
        check("wb_wd", wd_out, e.wd);
      end
    end
  endtask

  // Fetch requests are recognised by address == pc_out; tests keep data
  // addresses distinct from the PC.
  task automatic mem_model();
    bit is_fetch;
    mem_rvalid_in = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0 && rv_enable) begin
        mem_rvalid_in = 1'b1;
        mem_rdata_in  = rv_data;
      end
    end
    mem_ready_in = 1'b0;
    if (mem_req_out === 1'b1) begin
      is_fetch = (mem_addr_out === pc_out);
      if (!in_req) begin
        in_req = 1'b1;
        stall_left = is_fetch ? 0 : data_stall;
      end
      if (stall_left == 0) begin
        mem_ready_in = 1'b1;
        in_req = 1'b0;
        if (mem_we_out) begin
          st_count++;
          st_addr = mem_addr_out;
          st_data = mem_wdata_out;
        end else begin
          rv_cnt  = is_fetch ? 1 : data_rv_lat;
          rv_data = is_fetch ? imem_word : ld_data;
        end
      end else begin
        stall_left--;
      end
    end else begin
      in_req = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
    mem_model();
  endtask

  task automatic set_instr(input Itype t, input logic [4:0] rd, input logic [31:0] data,
                           input logic [31:0] addr, input logic [31:0] npc,
                           input logic [31:0] r2, input logic [31:0] word);
    iType_in = t; rd_in = rd; exec_data_in = data; exec_addr_in = addr;
    exec_next_pc_in = npc; rval2_in = r2; imem_word = word;
  endtask

  // Raises run_in for the fetch cycle only, then waits for retirement or trap.
  // lat = cycles from the FETCH cycle to the first cycle the result is visible.
  task automatic run_instr(input int budget, output int lat, output logic [31:0] faddr);
    logic [31:0] r0;
    logic        t0;
    int          start;
    r0 = retired_out; t0 = trap_out;
    run_in = 1'b1;
    tick();
    run_in = 1'b0;
    start = cyc;
    faddr = req_start_addr;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (retired_out !== r0 || trap_out !== t0) begin
        lat = cyc - start;
        break;
      end
    end
    n_cmp++;
    assert (lat >= 0) else begin
      n_bad++;
      $error("FAIL instr_done: observed no completion expected completion within %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0; run_in = 1'b0;
    tick(); tick();
    rst_n_in = 1'b1;
    tick();
  endtask

  initial begin
    int lat, w0, s0, r0;
    logic [31:0] fa;
    rst_n_in = 1'b0; run_in = 1'b0; iType_in = OP; rd_in = '0; rval2_in = '0;
    exec_data_in = '0; exec_addr_in = '0; exec_next_pc_in = '0;
    mem_ready_in = 1'b0; mem_rvalid_in = 1'b0; mem_rdata_in = '0;
    repeat (3) tick();
    rst_n_in = 1'b1;
    tick();
    check("rst_pc", pc_out, 32'h0);
    check("rst_inst", inst_out, 32'h0000_0013);
    check("rst_req", 32'(mem_req_out), 32'd0);
    check("rst_mem_we", 32'(mem_we_out), 32'd0);
    check("rst_mem_addr", mem_addr_out, 32'h0);
    check("rst_mem_wdata", mem_wdata_out, 32'h0);
    check("rst_we", 32'(we_out), 32'd0);
    check("rst_wa", 32'(wa_out), 32'd0);
    check("rst_wd", wd_out, 32'h0);
    check("rst_retired", retired_out, 32'd0);
    check("rst_trap", 32'(trap_out), 32'd0);
    check("rst_cause", 32'(trap_cause_out), 32'd0);

    // addi a1, a1, 1 with run_in dropped mid-instruction
    set_instr(OPIMM, 5'd11, 32'h55, 32'h55, 32'h4, 32'h0, 32'h0015_8593);
    wb_q.push_back('{5'd11, 32'h55});
    run_instr(40, lat, fa);
    check("alu_fetch_addr", fa, 32'h0);
    check("alu_latency", 32'(lat), 32'd5);
    check("alu_pc", pc_out, 32'h4);
    check("alu_retired", retired_out, 32'd1);
    check("alu_inst", inst_out, 32'h0015_8593);
    r0 = req_starts;
    repeat (4) tick();
    check("idle_req", 32'(mem_req_out), 32'd0);
    check("idle_no_new_req", 32'(req_starts - r0), 32'd0);

    // load with three stall cycles before ready
    set_instr(LOAD, 5'd5, 32'h1234, 32'h100, 32'h8, 32'h0, 32'h0000_2283);
    ld_addr = 32'h100; ld_data = 32'hDEAD_BEEF; data_stall = 3;
    wb_q.push_back('{5'd5, 32'hDEAD_BEEF});
    w0 = we_count;
    run_instr(40, lat, fa);
    data_stall = 0;
    check("ld_fetch_addr", fa, 32'h4);
    check("ld_latency", 32'(lat), 32'd10);
    check("ld_we_once", 32'(we_count - w0), 32'd1);
    check("ld_pc", pc_out, 32'h8);

    // zero-wait store
    set_instr(STORE, 5'd7, 32'h999, 32'h200, 32'hC, 32'hCAFE_F00D, 32'h0070_2023);
    s0 = st_count;
    run_instr(40, lat, fa);
    check("st_latency", 32'(lat), 32'd6);
    check("st_count", 32'(st_count - s0), 32'd1);
    check("st_addr", st_addr, 32'h200);
    check("st_data", st_data, 32'hCAFE_F00D);
    check("st_pc", pc_out, 32'hC);
    check("st_retired", retired_out, 32'd3);

    // branch taken to 0x40
    set_instr(BRANCH, 5'd3, 32'h1, 32'h40, 32'h40, 32'h0, 32'h0200_0a63);
    run_instr(40, lat, fa);
    check("br_latency", 32'(lat), 32'd5);
    check("br_pc", pc_out, 32'h40);

    // zero-wait load to x0: no register write
    set_instr(LOAD, 5'd0, 32'h0, 32'h104, 32'h44, 32'h0, 32'h1040_2003);
    ld_addr = 32'h104; ld_data = 32'h1357_9BDF;
    w0 = we_count;
    run_instr(40, lat, fa);
    check("ldx0_latency", 32'(lat), 32'd7);
    check("ldx0_no_we", 32'(we_count - w0), 32'd0);
    check("ldx0_pc", pc_out, 32'h44);

    // misaligned store traps before any data request
    set_instr(STORE, 5'd0, 32'h0, 32'h102, 32'h48, 32'h1111, 32'h1010_2123);
    r0 = req_starts;
    run_instr(40, lat, fa);
    check("mis_trap", 32'(trap_out), 32'd1);
    check("mis_cause", 32'(trap_cause_out), 32'd2);
    check("mis_pc", pc_out, 32'h44);
    check("mis_only_fetch", 32'(req_starts - r0), 32'd1);
    check("mis_retired", retired_out, 32'd5);
    r0 = req_starts;
    run_in = 1'b1;
    repeat (5) tick();
    run_in = 1'b0;
    check("trap_no_req", 32'(req_starts - r0), 32'd0);
    check("trap_sticky", 32'(trap_out), 32'd1);

    // fetch response never arrives
    do_reset();
    check("rst2_trap", 32'(trap_out), 32'd0);
    check("rst2_pc", pc_out, 32'h0);
    rv_enable = 1'b0;
    set_instr(OP, 5'd1, 32'h0, 32'h0, 32'h4, 32'h0, 32'h0000_00b3);
    run_instr(40, lat, fa);
    rv_enable = 1'b1;
    check("to_latency", 32'(lat), 32'd9);
    check("to_trap", 32'(trap_out), 32'd1);
    check("to_cause", 32'(trap_cause_out), 32'd3);

    // reset during MEM_WAIT; stale response lands the cycle after reset
    do_reset();
    set_instr(LOAD, 5'd6, 32'h0, 32'h180, 32'h8, 32'h0, 32'h1800_2303);
    ld_addr = 32'h180; ld_data = 32'hBAD0_BAD0; data_rv_lat = 2;
    run_in = 1'b1;
    tick();
    run_in = 1'b0;
    repeat (4) tick();
    check("rmw_mem_addr", mem_addr_out, 32'h180);
    tick();
    rst_n_in = 1'b0;
    tick();
    check("rmw_reset_req", 32'(mem_req_out), 32'd0);
    check("rmw_reset_pc", pc_out, 32'h0);
    rst_n_in = 1'b1; run_in = 1'b1; data_rv_lat = 1;
    set_instr(OP, 5'd9, 32'h77, 32'h0, 32'h4, 32'h0, 32'h0073_04b3);
    wb_q.push_back('{5'd9, 32'h77});
    tick();
    run_in = 1'b0;
    check("rmw_fetch_req", 32'(mem_req_out), 32'd1);
    check("rmw_fetch_addr", mem_addr_out, 32'h0);
    check("rmw_retired0", retired_out, 32'd0);
    check("rmw_inst_nop", inst_out, 32'h0000_0013);
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (retired_out !== 32'd0) begin
        lat = i;
        break;
      end
    end
    n_cmp++;
    assert (lat >= 0) else begin
      n_bad++;
      $error("FAIL rmw_done: observed no retirement expected retirement within 30 cycles");
    end
    check("rmw_retired1", retired_out, 32'd1);
    check("rmw_pc", pc_out, 32'h4);
    check("rmw_inst", inst_out, 32'h0073_04b3);

    check("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
